// File: rtl/interrupt_ack_controller_pkg.sv
// Shared types and constants for the interrupt acknowledge controller.
// State encodings, the spurious vector value, and the device IDs driven on the bus.
package interrupt_ack_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int SPURIOUS_VECTOR = 0;

  localparam logic [31:0] DEV0_ID = 32'h0000_0001;
  localparam logic [31:0] DEV1_ID = 32'h0000_0002;
  localparam logic [31:0] DEV2_ID = 32'h0000_0003;

endpackage

// File: rtl/ack_timeout_counter.sv
// Wait counter for the acknowledge phase.
// Holds at the terminal count instead of wrapping.
module ack_timeout_counter
  import interrupt_ack_controller_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/interrupt_ack_controller.sv
// CPU-side interrupt handshake: raise irq, drive INTA,
// capture the device ID as the vector or flag a spurious timeout.
module interrupt_ack_controller
  import interrupt_ack_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  int_in,
  input  logic                  int_en,
  input  logic                  cpu_ack,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  irq,
  output logic                  inta,
  output logic [DATA_WIDTH-1:0] vector,
  output logic                  vector_valid,
  output logic                  spurious,
  output logic                  busy
);

  state_e                  state_q, state_d;
  logic                    irq_q, irq_d;
  logic                    inta_q, inta_d;
  logic [DATA_WIDTH-1:0]   vector_q, vector_d;
  logic                    vv_q, vv_d;
  logic                    spur_q, spur_d;
  logic                    cnt_clr;
  logic                    cnt_en;
  logic                    cnt_tc;
  logic                    bus_hit;

  assign bus_hit = (data_in != '0);
  assign cnt_clr = (state_q != ACK);

  ack_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    inta_d   = inta_q;
    vector_d = vector_q;
    vv_d     = 1'b0;
    spur_d   = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        irq_d  = 1'b0;
        inta_d = 1'b0;
        if (int_in && int_en) begin
          state_d = PEND;
          irq_d   = 1'b1;
        end
      end
      PEND: begin
        irq_d = 1'b1;
        // an accepted ack beats a same-cycle withdrawal
        if (cpu_ack) begin
          state_d = ACK;
          inta_d  = 1'b1;
          irq_d   = 1'b0;
        end else if (!int_en || !int_in) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      ACK: begin
        irq_d  = 1'b0;
        inta_d = 1'b1;
        if (bus_hit) begin
          state_d  = RELEASE;
          vector_d = data_in;
          vv_d     = 1'b1;
          inta_d   = 1'b0;
        end else if (cnt_tc) begin
          state_d  = RELEASE;
          vector_d = DATA_WIDTH'(SPURIOUS_VECTOR);
          vv_d     = 1'b1;
          spur_d   = 1'b1;
          inta_d   = 1'b0;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        irq_d   = 1'b0;
        inta_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
        inta_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      inta_q   <= 1'b0;
      vector_q <= '0;
      vv_q     <= 1'b0;
      spur_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      inta_q   <= inta_d;
      vector_q <= vector_d;
      vv_q     <= vv_d;
      spur_q   <= spur_d;
    end
  end

  assign irq          = irq_q;
  assign inta         = inta_q;
  assign vector       = vector_q;
  assign vector_valid = vv_q;
  assign spurious     = spur_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_interrupt_ack_controller.sv
// Scoreboard bench for interrupt_ack_controller.
// Device answers after a random latency; outcomes predicted from the timing rules.
module tb_interrupt_ack_controller;

  localparam int DW      = 32;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int NO_DEV  = 99;

  typedef struct {
    logic [DW-1:0] vec;
    logic          spur;
    int            inta_cycles;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          int_in;
  logic          int_en;
  logic          cpu_ack;
  logic [DW-1:0] data_in;
  logic          irq;
  logic          inta;
  logic [DW-1:0] vector;
  logic          vector_valid;
  logic          spurious;
  logic          busy;

  exp_t sbq[$];
  int   n_checks;
  int   n_fail;
  int   inta_len;
  logic prev_vv;

  interrupt_ack_controller #(
    .DATA_WIDTH (DW),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .int_in       (int_in),
    .int_en       (int_en),
    .cpu_ack      (cpu_ack),
    .data_in      (data_in),
    .irq          (irq),
    .inta         (inta),
    .vector       (vector),
    .vector_valid (vector_valid),
    .spurious     (spurious),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a device that drives its ID lat cycles after INTA rose
  // is seen on edge lat+1; the controller gives up on edge TIMEOUT.
  function automatic exp_t predict(input logic [DW-1:0] id,
                                   input int lat);
    exp_t e;
    if (lat + 1 <= TIMEOUT) begin
      e.vec         = id;
      e.spur        = 1'b0;
      e.inta_cycles = lat + 1;
    end else begin
      e.vec         = '0;
      e.spur        = 1'b1;
      e.inta_cycles = TIMEOUT;
    end
    return e;
  endfunction

  // Monitor: compares every vector_valid pulse with the scoreboard head.
  initial begin
    inta_len = 0;
    prev_vv  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        inta_len = 0;
        prev_vv  = 1'b0;
      end else begin
        if (prev_vv)
          check("vv_pulse_width", {31'd0, vector_valid}, 32'd0);
        if (inta)
          inta_len++;
        if (vector_valid) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got vector %h, expected none",
                     vector);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            check("vector", vector, e.vec);
            check("spurious", {31'd0, spurious}, {31'd0, e.spur});
            check("inta_cycles", inta_len, e.inta_cycles);
          end
          inta_len = 0;
        end
        prev_vv = vector_valid;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [DW-1:0] id,
                         input int lat,
                         input bit race);
    int k;
    int_in = 1'b1;
    step();
    check("irq_rise", {31'd0, irq}, 32'd1);
    cpu_ack = 1'b1;
    if (race) int_in = 1'b0;
    step();
    cpu_ack = 1'b0;
    check("inta_rise", {31'd0, inta}, 32'd1);
    sbq.push_back(predict(id, lat));
    k = 0;
    while (inta && k < 30) begin
      if (k == lat) data_in = id;
      step();
      k++;
    end
    if (k >= 30) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_bound: inta still %b after %0d cycles, expected 0",
               inta, k);
    end
    data_in = '0;
    int_in  = 1'b0;
    step();
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] id;
    bit            stuck;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    int_in   = 1'b1;
    int_en   = 1'b1;
    cpu_ack  = 1'b0;
    data_in  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_inta", {31'd0, inta}, 32'd0);
    check("rst_vector", vector, 32'd0);
    check("rst_vv", {31'd0, vector_valid}, 32'd0);
    check("rst_spur", {31'd0, spurious}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step();
    check("irq_after_rst", {31'd0, irq}, 32'd1);

    int_in = 1'b0;
    step();
    check("withdraw_irq", {31'd0, irq}, 32'd0);
    check("withdraw_busy", {31'd0, busy}, 32'd0);

    run_txn(32'h0000_0001, 1, 1'b0);

    int_en = 1'b0;
    int_in = 1'b1;
    stuck  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (irq) stuck = 1'b1;
    end
    check("masked_irq", {31'd0, stuck}, 32'd0);
    int_en = 1'b1;
    step();
    check("unmask_irq", {31'd0, irq}, 32'd1);
    int_in = 1'b0;
    step();
    check("unmask_withdraw", {31'd0, irq}, 32'd0);

    run_txn('0, NO_DEV, 1'b0);
    run_txn(32'hdead_beef, TIMEOUT - 1, 1'b0);
    run_txn(32'h1234_5678, TIMEOUT, 1'b0);
    run_txn('0, NO_DEV, 1'b1);

    for (int t = 0; t < 12; t++) begin
      id = $urandom;
      if (id == '0) id = 32'h5;
      run_txn(id, int'($urandom_range(1, 10)), 1'b0);
    end

    run_txn(32'hcafe_0001, 2, 1'b0);
    int_in = 1'b1;
    step();
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    check("midack_inta_up", {31'd0, inta}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("midack_inta", {31'd0, inta}, 32'd0);
    check("midack_vector", vector, 32'd0);
    check("midack_vv", {31'd0, vector_valid}, 32'd0);
    int_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    for (int w = 0; w < 20 && sbq.size() != 0; w++) step();
    check("sb_drained", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
